// File: rtl/apb_spi_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_req_arbiter_if
// Brief    : Requester-side and APB/SPI-side signal bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_spi_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rsp_data;
    logic [7:0]           out_data;
    logic [7:0]           out_addr;
    logic                 out_valid;
    logic                 pready;
    logic [7:0]           read_data;
    logic                 busy;

    modport slave (
        input  req, req_data, req_addr, pready, read_data,
        output gnt, done, err, rsp_data, out_data, out_addr, out_valid, busy
    );

    modport master (
        output req, req_data, req_addr, pready, read_data,
        input  gnt, done, err, rsp_data, out_data, out_addr, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/apb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_req_arbiter
// Brief    : Round-robin sequencer sharing one APB/SPI path among NUM_REQ users.
// Revision : 1.0 - initial release
// ============================================================================
module apb_spi_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    apb_spi_req_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err;
    logic [7:0]         r_rsp;
    logic [7:0]         r_out_data;
    logic [7:0]         r_out_addr;

    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    logic [NUM_REQ-1:0] w_gnt_sel;
    logic [IDX_W-1:0]   w_ptr_next;
    int                 w_dist;
    int                 w_best;

    // Pick the set request closest above the pointer, measured with wrap-around.
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_dist = 0;
        w_best = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (bus.req[j]) begin
                w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
                if (!w_any || (w_dist < w_best)) begin
                    w_best = w_dist;
                    w_sel  = IDX_W'(j);
                    w_any  = 1'b1;
                end
            end
        end
    end

    assign w_gnt_sel  = NUM_REQ'(1) << w_sel;
    assign w_ptr_next = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_rsp      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx      <= w_sel;
                        r_gnt      <= w_gnt_sel;
                        r_out_data <= bus.req_data[{w_sel, 3'b000} +: 8];
                        r_out_addr <= bus.req_addr[{w_sel, 3'b000} +: 8];
                        r_state    <= S_ISSUE;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A ready arriving on the last allowed cycle still completes cleanly.
                    if (bus.pready) begin
                        if (!r_out_addr[7]) begin
                            r_rsp <= bus.read_data;
                        end
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end else if (r_cnt == C_TMO_LAST) begin
                        r_done  <= r_gnt;
                        r_err   <= 1'b1;
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rsp_data  = r_rsp;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_valid = (r_state == S_ISSUE);
    assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
endmodule
`default_nettype wire
